// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
// One outstanding request: req/ready handshake, then a single rvalid beat with rdata.
interface fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, input ready, rvalid, rdata);
    modport slave  (input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/fetch_stage.sv
// RV32I fetch stage and IF/ID register: owns PCF, one outstanding imem fetch, skid buffer.
// Optional bubble counter on FetchBubbles enabled by defining FETCH_PERF_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               StallF,
    input  logic               StallD,
    input  logic               FlushD,
    input  logic               PCSrcE,
    input  logic [31:0]        PCTargetE,
    fetch_stage_if.master      imem,
    output logic [31:0]        InstrD,
    output logic [31:0]        PCD,
    output logic [31:0]        PCPlus4D,
    output logic               ValidD,
    output logic [31:0]        FetchBubbles
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_FULL} state_t;

    state_t      state;
    logic [31:0] pcf;
    logic [31:0] skid;
    logic [31:0] target;
    logic [31:0] pc_next4;
    logic [31:0] deliver_word;
    logic        deliver;

    assign target   = PCTargetE & ~32'd3;
    assign pc_next4 = pcf + 32'd4;

    assign imem.req  = (state == S_REQ) && !StallF && !PCSrcE;
    assign imem.addr = pcf;

    // A word reaches IF/ID either straight off the bus or out of the skid buffer.
    assign deliver      = !PCSrcE && !StallD &&
                          (((state == S_WAIT) && imem.rvalid) || (state == S_FULL));
    assign deliver_word = (state == S_FULL) ? skid : imem.rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_REQ;
            pcf   <= RESET_PC;
            skid  <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (PCSrcE)
                        pcf <= target;
                    else if (imem.req && imem.ready)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem.rvalid) begin
                        if (PCSrcE) begin
                            pcf   <= target;
                            state <= S_REQ;
                        end else if (!StallD) begin
                            pcf   <= pc_next4;
                            state <= S_REQ;
                        end else begin
                            skid  <= imem.rdata;
                            state <= S_FULL;
                        end
                    end else if (PCSrcE) begin
                        pcf   <= target;
                        state <= S_DROP;
                    end
                end
                // Stale response still in flight; swallow it before refetching.
                S_DROP: begin
                    if (PCSrcE)
                        pcf <= target;
                    if (imem.rvalid)
                        state <= S_REQ;
                end
                S_FULL: begin
                    if (PCSrcE) begin
                        pcf   <= target;
                        state <= S_REQ;
                    end else if (!StallD) begin
                        pcf   <= pc_next4;
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end else if (StallD) begin
            InstrD <= InstrD;
        end else if (deliver) begin
            InstrD   <= deliver_word;
            PCD      <= pcf;
            PCPlus4D <= pc_next4;
            ValidD   <= 1'b1;
        end else begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end
    end

`ifdef FETCH_PERF_EN
    logic bubble;
    assign bubble = !FlushD && !StallD && !deliver;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            FetchBubbles <= '0;
        else if (bubble)
            FetchBubbles <= FetchBubbles + 32'd1;
    end
`else
    assign FetchBubbles = 32'h0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then randomized traffic, checked against a
// program-order model (expected next PC, memory word function, bubble count).
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        stall_f, stall_d, flush_d, pcsrc_e;
    logic [31:0] target_e;
    logic [31:0] instr_d, pc_d, pcplus4_d, bubbles;
    logic        valid_d;

    fetch_stage_if imem ();

    fetch_stage dut (
        .clk(clk), .reset(reset), .StallF(stall_f), .StallD(stall_d), .FlushD(flush_d),
        .PCSrcE(pcsrc_e), .PCTargetE(target_e), .imem(imem), .InstrD(instr_d),
        .PCD(pc_d), .PCPlus4D(pcplus4_d), .ValidD(valid_d), .FetchBubbles(bubbles)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] NOP = 32'h0000_0013;

    int          n_vec = 0, n_err = 0;
    logic [31:0] exp_pc, exp_bub;
    bit          pend, const_data, noise, first, logging;
    int          cnt, cyc, delivered;
    logic [31:0] pend_addr;
    bit          p_stall_d, p_flush_d, p_pcsrc;
    logic [31:0] o_instr, o_pc, o_pc4;
    logic [31:0] log_a[$];
    int          log_c[$];

    function automatic logic [31:0] word(input logic [31:0] a);
        return const_data ? 32'h0050_0093 : (a ^ 32'h5A5A_0003);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_edge();
        if (p_flush_d) begin
            chk("flush_instr", instr_d, NOP);
            chk("flush_valid", {31'b0, valid_d}, 32'd0);
            chk("flush_pcd", pc_d, o_pc);
            chk("flush_pc4", pcplus4_d, o_pc4);
        end else if (p_stall_d) begin
            chk("hold_instr", instr_d, o_instr);
            chk("hold_pcd", pc_d, o_pc);
            chk("hold_pc4", pcplus4_d, o_pc4);
        end else if (p_pcsrc) begin
            chk("redir_valid", {31'b0, valid_d}, 32'd0);
            chk("redir_instr", instr_d, NOP);
        end else if (valid_d) begin
            chk("pcd", pc_d, exp_pc);
            chk("instr", instr_d, word(exp_pc));
            chk("pc4", pcplus4_d, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end else begin
            chk("bubble_instr", instr_d, NOP);
        end
        if (!p_flush_d && !p_stall_d && !valid_d)
            exp_bub = exp_bub + 32'd1;
`ifdef FETCH_PERF_EN
        chk("bubbles", bubbles, exp_bub);
`else
        chk("bubbles", bubbles, 32'd0);
`endif
        o_instr = instr_d;
        o_pc    = pc_d;
        o_pc4   = pcplus4_d;
    endtask

    task automatic do_reset(input bit cd);
        reset = 1'b1;
        stall_f = 0; stall_d = 0; flush_d = 0; pcsrc_e = 0; target_e = '0;
        imem.ready = 0; imem.rvalid = 0; imem.rdata = '0;
        pend = 0; cnt = 0; const_data = cd; first = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_pc = 32'h0; exp_bub = 32'h0;
        #1;
        chk("rst_instr", instr_d, NOP);
        chk("rst_pcd", pc_d, 32'h0);
        chk("rst_pc4", pcplus4_d, 32'h0);
        chk("rst_valid", {31'b0, valid_d}, 32'd0);
        chk("rst_bubbles", bubbles, 32'h0);
        chk("rst_addr", imem.addr, 32'h0);
        o_instr = NOP; o_pc = '0; o_pc4 = '0;
    endtask

    // Called at a negedge: check the previous edge, drive the next cycle, advance one edge.
    task automatic step(input bit sf, input bit sd, input bit fd, input bit ps,
                        input logic [31:0] tg, input bit rdy, input int lat);
        bit          hs, rv;
        logic [31:0] a;
        if (!first) check_edge();
        first = 0;
        stall_f = sf; stall_d = sd; flush_d = fd; pcsrc_e = ps; target_e = tg;
        imem.ready = rdy;
        if (pend && cnt == 0) begin
            imem.rvalid = 1'b1;
            imem.rdata  = word(pend_addr);
        end else begin
            if (pend) cnt--;
            imem.rvalid = !pend && noise && ($urandom_range(0, 7) == 0);
            imem.rdata  = $urandom;
        end
        #1;
        if (imem.req) begin
            chk("addr", imem.addr, exp_pc);
            chk("one_outstanding", {31'b0, pend}, 32'd0);
            if (logging) begin
                log_a.push_back(imem.addr);
                log_c.push_back(cyc);
            end
        end
        if (sf || ps) chk("req_suppressed", {31'b0, imem.req}, 32'd0);
        hs = imem.req && rdy;
        a  = imem.addr;
        rv = imem.rvalid;
        p_stall_d = sd; p_flush_d = fd; p_pcsrc = ps;
        @(posedge clk);
        if (rv && pend) pend = 0;
        if (hs) begin
            pend = 1; pend_addr = a; cnt = lat;
        end
        if (ps) exp_pc = tg & ~32'd3;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        cyc = 0; delivered = 0; noise = 0; logging = 1;
        do_reset(1);

        // Zero-wait streaming, then a stalled response parked in the skid buffer.
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("first_instr", instr_d, 32'h0050_0093);
        chk("first_pcd", pc_d, 32'h0);
        chk("first_pc4", pcplus4_d, 32'h4);
        chk("first_valid", {31'b0, valid_d}, 32'd1);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 1, 0);
        chk("skid_hold_pcd", pc_d, 32'h4);
        step(0, 1, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("skid_pcd", pc_d, 32'h8);
        chk("skid_valid", {31'b0, valid_d}, 32'd1);

        // Redirect while the fetch of 12 is in flight.
        step(0, 0, 0, 0, 0, 1, 2);
        step(0, 0, 0, 1, 32'h100, 1, 0);
        chk("drop_valid0", {31'b0, valid_d}, 32'd0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("drop_valid1", {31'b0, valid_d}, 32'd0);
        step(0, 0, 0, 0, 0, 1, 0);

        // Flush and stall together while the response lands.
        step(0, 1, 1, 0, 0, 1, 0);
        chk("flushstall_instr", instr_d, NOP);
        chk("flushstall_valid", {31'b0, valid_d}, 32'd0);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("after_flush_pcd", pc_d, 32'h100);

        // PC wrap at the top of the address space.
        step(0, 0, 0, 1, 32'hFFFF_FFFF, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("wrap_pcd", pc_d, 32'hFFFF_FFFC);
        chk("wrap_pc4", pcplus4_d, 32'h0);
        step(0, 0, 0, 0, 0, 1, 0);

        chk("log_len", log_a.size(), 32'd7);
        if (log_a.size() >= 7) begin
            chk("log_a0", log_a[0], 32'h0);          chk("log_c0", log_c[0], 32'd0);
            chk("log_a1", log_a[1], 32'h4);          chk("log_c1", log_c[1], 32'd2);
            chk("log_a2", log_a[2], 32'h8);          chk("log_c2", log_c[2], 32'd4);
            chk("log_a3", log_a[3], 32'hC);          chk("log_c3", log_c[3], 32'd8);
            chk("log_a4", log_a[4], 32'h100);        chk("log_c4", log_c[4], 32'd12);
            chk("log_a5", log_a[5], 32'hFFFF_FFFC);  chk("log_a6", log_a[6], 32'h0);
        end
        logging = 0;

        // Memory never ready: every cycle loads a bubble.
        do_reset(0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0);
`ifdef FETCH_PERF_EN
        chk("perf_bubbles5", bubbles, 32'd5);
`else
        chk("perf_bubbles5", bubbles, 32'd0);
`endif

        noise = 1;
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] tg;
            if (i == 2000) do_reset(0);
            tg = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 0,
                 $urandom_range(0, 9) == 0, tg, $urandom_range(0, 3) != 0, $urandom_range(0, 3));
        end
        check_edge();
        chk("liveness", {31'b0, delivered > 300}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
